// File: rtl/cv32e40p_tb_obi_mem_pkg.sv
// Shared constants and response-entry type for the multi-port OBI memory model.
package cv32e40p_tb_obi_mem_pkg;

  localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
  localparam logic [31:0] PASS_MAGIC  = 32'd123456789;

  // Wide enough to hold the largest response latency (8).
  localparam int unsigned AGE_W = 4;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [AGE_W-1:0] age;
  } obi_resp_t;

  function automatic logic is_mmio(input logic [31:0] addr);
    return (addr == STATUS_ADDR) || (addr == EXIT_ADDR);
  endfunction

endpackage

// File: rtl/cv32e40p_tb_resp_fifo.sv
// Per-port in-order response FIFO; each entry ages until it reaches LATENCY,
// at which point the head is presented as rvalid and popped in the same cycle.
module cv32e40p_tb_resp_fifo
  import cv32e40p_tb_obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] push_rdata_i,
  output logic        full_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);

  obi_resp_t       q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            empty;

  assign empty    = (count == '0);
  assign full_o   = (count == CW'(DEPTH));
  assign rvalid_o = ~empty & (q[rd_ptr].age == LAT);
  assign rdata_o  = rvalid_o ? q[rd_ptr].rdata : '0;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].age != LAT) q[i].age <= q[i].age + 1'b1;
      end
      // The push cycle already counts as one cycle of age, so a transfer in
      // cycle t becomes visible exactly in cycle t+LATENCY.
      if (push_i) begin
        q[wr_ptr].rdata <= push_rdata_i;
        q[wr_ptr].age   <= AGE_W'(1);
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (rvalid_o) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push_i) - CW'(rvalid_o);
    end
  end

endmodule

// File: rtl/cv32e40p_tb_obi_mem.sv
// Multi-port OBI memory model with test-status/exit pseudo-peripherals.
// Optional random grant stalls: define CV32E40P_TB_OBI_MEM_RANDOM_STALL_EN.
module cv32e40p_tb_obi_mem
  import cv32e40p_tb_obi_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH  = 20,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_PORTS-1:0]       req_i,
  output logic [NUM_PORTS-1:0]       gnt_o,
  input  logic [NUM_PORTS-1:0][31:0] addr_i,
  input  logic [NUM_PORTS-1:0]       we_i,
  input  logic [NUM_PORTS-1:0][3:0]  be_i,
  input  logic [NUM_PORTS-1:0][31:0] wdata_i,
  output logic [NUM_PORTS-1:0][31:0] rdata_o,
  output logic [NUM_PORTS-1:0]       rvalid_o,
  output logic                       tests_passed_o,
  output logic                       tests_failed_o,
  output logic                       exit_valid_o,
  output logic [31:0]                exit_value_o
);

  localparam int unsigned WORDS = 2 ** (RAM_ADDR_WIDTH - 2);

  logic [31:0]                 mem [WORDS];
  logic [NUM_PORTS-1:0]        fifo_full;
  logic [NUM_PORTS-1:0]        stall;
  logic [NUM_PORTS-1:0]        xfer;
  logic [NUM_PORTS-1:0][31:0]  push_rdata;

  logic        status_hit;
  logic        status_pass;
  logic        exit_hit;
  logic [31:0] exit_wdata;

`ifdef CV32E40P_TB_OBI_MEM_RANDOM_STALL_EN
  logic [NUM_PORTS-1:0][15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) lfsr[p] <= 16'hACE1 + 16'(p);
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        lfsr[p] <= {lfsr[p][14:0],
                    lfsr[p][15] ^ lfsr[p][13] ^ lfsr[p][12] ^ lfsr[p][10]};
      end
    end
  end

  always_comb begin
    stall = '0;
    for (int p = 0; p < NUM_PORTS; p++) stall[p] = (lfsr[p][1:0] == 2'b00);
  end
`else
  assign stall = '0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // A full FIFO still accepts when its head pops in the same cycle.
    assign gnt_o[p] = req_i[p] & (~fifo_full[p] | rvalid_o[p]) & ~stall[p];
    assign xfer[p]  = req_i[p] & gnt_o[p];

    // Combinational read of pre-write contents: same-cycle read/write sees old data.
    assign push_rdata[p] = (we_i[p] || is_mmio(addr_i[p])) ? '0
                         : mem[addr_i[p][RAM_ADDR_WIDTH-1:2]];

    cv32e40p_tb_resp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .LATENCY (RVALID_LATENCY)
    ) u_resp_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (xfer[p]),
      .push_rdata_i (push_rdata[p]),
      .full_o       (fifo_full[p]),
      .rvalid_o     (rvalid_o[p]),
      .rdata_o      (rdata_o[p])
    );
  end

  // Ascending port order: the higher port index overwrites per enabled byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (xfer[p] && we_i[p] && !is_mmio(addr_i[p])) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[p][b]) mem[addr_i[p][RAM_ADDR_WIDTH-1:2]][8*b +: 8] <= wdata_i[p][8*b +: 8];
        end
      end
    end
  end

  // Descending scan so the lowest-index writer is the one that sticks.
  always_comb begin
    status_hit  = 1'b0;
    status_pass = 1'b0;
    exit_hit    = 1'b0;
    exit_wdata  = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (xfer[p] && we_i[p] && (addr_i[p] == STATUS_ADDR)) begin
        status_hit  = 1'b1;
        status_pass = (wdata_i[p] == PASS_MAGIC);
      end
      if (xfer[p] && we_i[p] && (addr_i[p] == EXIT_ADDR)) begin
        exit_hit   = 1'b1;
        exit_wdata = wdata_i[p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else begin
      if (status_hit && status_pass)  tests_passed_o <= 1'b1;
      if (status_hit && !status_pass) tests_failed_o <= 1'b1;
      if (exit_hit) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= exit_wdata;
      end
    end
  end

endmodule
